lcd_de_rx: RTL and testbench

//  Sink end of the 800x480 DE-mode RGB565 LCD link (clock + DEN + R5/G6/B5, no HSYNC/VSYNC).

---
 rtl/lcd_de_rx.sv | 159 +++++++++++++++
 tb/tb_lcd_de_rx.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/lcd_de_rx.sv
// lcd_de_rx
//    Receive end of a DE-mode RGB565 LCD link (clock, DEN and R5/G6/B5; no
//    HSYNC or VSYNC). Line and frame boundaries are recovered from DEN alone.
//    The block emits a registered pixel stream with x/y coordinates, measures
//    line length and line count, flags timing errors and reports lock.
//
// Ports
//    i_clk, i_rst        pixel clock; asynchronous active-high reset
//    i_den, i_R/G/B      data enable and pixel colour from the link
//    o_valid             o_x/o_y/o_R/o_G/o_B hold an in-range pixel
//    o_x, o_y            pixel column and row
//    o_R, o_G, o_B       registered pixel colour
//    o_sof               pulses with pixel (0,0)
//    o_eol               pulses in the cycle after the last pixel of a line
//    o_eof               pulses when vertical blank is confirmed after a frame
//    o_line_len          DEN-high length of the last completed line
//    o_frame_lines       line count of the last completed frame
//    o_err_hlen          pulses when the last line length != H_ACTIVE
//    o_err_vlen          pulses with o_eof when the frame line count != V_ACTIVE
//    o_locked            level: the last frame was error-free
//
// state    | meaning
// ---------+------------------------------------------------------------------
// S_SEARCH | after reset; wait for vertical blank, ignore partial frame
// S_ARMED  | vertical blank seen; next DEN rise is pixel (0,0)
// S_ACTIVE | inside a line, one pixel per DEN-high cycle
// S_HBLANK | between lines; DEN rise starts a new line, vblank ends the frame
module lcd_de_rx #(
   parameter int H_ACTIVE   = 800,
   parameter int V_ACTIVE   = 480,
   parameter int VBLANK_MIN = 2048,
   parameter int CW         = 12
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_den,
   input  logic [4:0]    i_R,
   input  logic [5:0]    i_G,
   input  logic [4:0]    i_B,
   output logic          o_valid,
   output logic [9:0]    o_x,
   output logic [9:0]    o_y,
   output logic [4:0]    o_R,
   output logic [5:0]    o_G,
   output logic [4:0]    o_B,
   output logic          o_sof,
   output logic          o_eol,
   output logic          o_eof,
   output logic [CW-1:0] o_line_len,
   output logic [CW-1:0] o_frame_lines,
   output logic          o_err_hlen,
   output logic          o_err_vlen,
   output logic          o_locked
);

   typedef enum logic [1:0] {S_SEARCH, S_ARMED, S_ACTIVE, S_HBLANK} state_t;

   localparam logic [CW-1:0] C_H     = CW'(H_ACTIVE);
   localparam logic [CW-1:0] C_V     = CW'(V_ACTIVE);
   localparam logic [CW-1:0] C_VB    = CW'(VBLANK_MIN);
   localparam logic [CW-1:0] C_VB_M1 = CW'(VBLANK_MIN - 1);
   localparam logic [CW-1:0] C_MAX   = '1;

   state_t        r_state, w_next;
   logic [CW-1:0] r_lowrun;
   logic [CW-1:0] r_x, r_y;
   logic          r_hlen_bad;

   logic          w_vb, w_pix, w_line_start, w_fall, w_eof, w_in_range;
   logic [CW-1:0] w_px_x, w_px_y, w_x_inc, w_y_inc;

   // vb fires only on the cycle the low run first reaches VBLANK_MIN; the
   // counter then saturates so it cannot fire again until DEN goes high.
   assign w_vb         = !i_den && (r_lowrun == C_VB_M1);
   assign w_line_start = i_den && (r_state == S_ARMED || r_state == S_HBLANK);
   assign w_pix        = i_den && (r_state != S_SEARCH);
   assign w_fall       = !i_den && (r_state == S_ACTIVE);
   assign w_eof        = w_vb && (r_state == S_HBLANK);
   assign w_px_x       = w_line_start ? '0 : r_x;
   assign w_px_y       = (r_state == S_ARMED) ? '0 : r_y;
   assign w_in_range   = (w_px_x < C_H) && (w_px_y < C_V);
   assign w_x_inc      = (w_px_x == C_MAX) ? C_MAX : w_px_x + 1'b1;
   assign w_y_inc      = (r_y == C_MAX) ? C_MAX : r_y + 1'b1;

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_SEARCH: if (w_vb)  w_next = S_ARMED;
         S_ARMED:  if (i_den) w_next = S_ACTIVE;
         S_ACTIVE: if (!i_den) w_next = S_HBLANK;
         S_HBLANK: begin
            if (i_den)     w_next = S_ACTIVE;
            else if (w_vb) w_next = S_ARMED;
         end
         default:  w_next = S_SEARCH;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state       <= S_SEARCH;
         r_lowrun      <= '0;
         r_x           <= '0;
         r_y           <= '0;
         r_hlen_bad    <= 1'b0;
         o_valid       <= 1'b0;
         o_x           <= '0;
         o_y           <= '0;
         o_R           <= '0;
         o_G           <= '0;
         o_B           <= '0;
         o_sof         <= 1'b0;
         o_eol         <= 1'b0;
         o_eof         <= 1'b0;
         o_line_len    <= '0;
         o_frame_lines <= '0;
         o_err_hlen    <= 1'b0;
         o_err_vlen    <= 1'b0;
         o_locked      <= 1'b0;
      end else begin
         r_state <= w_next;

         if (i_den)               r_lowrun <= '0;
         else if (r_lowrun != C_VB) r_lowrun <= r_lowrun + 1'b1;

         if (w_pix) r_x <= w_x_inc;

         if (r_state == S_ARMED && i_den) r_y <= '0;
         else if (w_fall)               r_y <= w_y_inc;

         o_valid <= w_pix && w_in_range;
         // Out-of-range pixels keep the last in-range coordinate and colour.
         if (w_pix && w_in_range) begin
            o_x <= 10'(w_px_x);
            o_y <= 10'(w_px_y);
            o_R <= i_R;
            o_G <= i_G;
            o_B <= i_B;
         end
         o_sof <= i_den && (r_state == S_ARMED);

         o_eol      <= w_fall;
         o_err_hlen <= w_fall && (r_x != C_H);
         if (w_fall) o_line_len <= r_x;

         o_eof      <= w_eof;
         o_err_vlen <= w_eof && (r_y != C_V);
         if (w_eof) o_frame_lines <= r_y;

         if (r_state == S_ARMED && i_den)   r_hlen_bad <= 1'b0;
         else if (w_fall && (r_x != C_H))   r_hlen_bad <= 1'b1;

         if (r_state == S_SEARCH)           o_locked <= 1'b0;
         else if (w_fall && (r_x != C_H))   o_locked <= 1'b0;
         else if (w_eof)                    o_locked <= !r_hlen_bad && (r_y == C_V);
      end
   end

endmodule

// File: tb/tb_lcd_de_rx.sv
// Directed bench for lcd_de_rx with a scaled-down raster (8x4 active,
// 4-cycle hblank, vblank confirmed after 16 low cycles, 5-bit counters).
module tb_lcd_de_rx;

   localparam int H   = 8;
   localparam int V   = 4;
   localparam int VBM = 16;
   localparam int CW  = 5;
   localparam int HB  = 4;
   localparam int VB  = 20;
   localparam int SAT = (1 << CW) - 1;

   logic          i_clk = 1'b0;
   logic          i_rst;
   logic          i_den;
   logic [4:0]    i_R;
   logic [5:0]    i_G;
   logic [4:0]    i_B;
   logic          o_valid;
   logic [9:0]    o_x, o_y;
   logic [4:0]    o_R;
   logic [5:0]    o_G;
   logic [4:0]    o_B;
   logic          o_sof, o_eol, o_eof;
   logic [CW-1:0] o_line_len, o_frame_lines;
   logic          o_err_hlen, o_err_vlen, o_locked;

   int            n_assert = 0;
   int            n_fail   = 0;
   logic [15:0]   last_rgb = '0;
   logic          exp_locked = 1'b0;

   lcd_de_rx #(.H_ACTIVE(H), .V_ACTIVE(V), .VBLANK_MIN(VBM), .CW(CW)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_den(i_den),
      .i_R(i_R), .i_G(i_G), .i_B(i_B),
      .o_valid(o_valid), .o_x(o_x), .o_y(o_y),
      .o_R(o_R), .o_G(o_G), .o_B(o_B),
      .o_sof(o_sof), .o_eol(o_eol), .o_eof(o_eof),
      .o_line_len(o_line_len), .o_frame_lines(o_frame_lines),
      .o_err_hlen(o_err_hlen), .o_err_vlen(o_err_vlen), .o_locked(o_locked)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one sample and look at the registered result just after the edge.
   task automatic tick(input logic den, input logic [15:0] px);
      i_den = den;
      {i_R, i_G, i_B} = px;
      @(posedge i_clk);
      #1;
   endtask

   task automatic send_line(input int len, input int y, input bit armed);
      logic [15:0] px;
      bit          ev;
      for (int i = 0; i < len; i++) begin
         px = 16'(y * 37 + i * 5 + 1);
         tick(1'b1, px);
         ev = armed && (i < H) && (y < V);
         check("valid", o_valid, ev);
         check("sof", o_sof, armed && i == 0 && y == 0);
         if (ev) begin
            check("x", o_x, i);
            check("y", o_y, y);
            last_rgb = px;
         end
         check("rgb", {o_R, o_G, o_B}, last_rgb);
      end
      tick(1'b0, 16'h0);
      check("eol", o_eol, armed);
      check("err_hlen", o_err_hlen, armed && len != H);
      if (armed) begin
         check("line_len", o_line_len, (len > SAT) ? SAT : len);
         if (len != H) exp_locked = 1'b0;
      end
      check("locked_line", o_locked, exp_locked);
      repeat (HB - 1) tick(1'b0, 16'h0);
   endtask

   task automatic send_frame(input int nlines, input int bad_line, input int bad_len,
                             input bit armed);
      bit ok;
      bit e;
      int len;
      ok = (nlines == V);
      for (int l = 0; l < nlines; l++) begin
         len = (l == bad_line) ? bad_len : H;
         if (len != H) ok = 1'b0;
         send_line(len, l, armed);
      end
      for (int j = HB + 1; j <= HB + VB; j++) begin
         tick(1'b0, 16'h0);
         e = armed && (j == VBM);
         check("eof", o_eof, e);
         check("err_vlen", o_err_vlen, e && nlines != V);
         if (e) begin
            check("frame_lines", o_frame_lines, nlines);
            exp_locked = ok;
            check("locked_eof", o_locked, exp_locked);
         end
      end
   endtask

   task automatic check_all_zero();
      check("rst_pix", {o_valid, o_x, o_y, o_R, o_G, o_B}, 64'h0);
      check("rst_ctl", {o_sof, o_eol, o_eof, o_line_len, o_frame_lines,
                        o_err_hlen, o_err_vlen, o_locked}, 64'h0);
   endtask

   task automatic do_reset();
      i_rst = 1'b1;
      #1;
      check_all_zero();
      last_rgb   = '0;
      exp_locked = 1'b0;
   endtask

   initial begin
      i_rst = 1'b0;
      i_den = 1'b0;
      {i_R, i_G, i_B} = '0;
      #2;
      do_reset();
      @(posedge i_clk);
      #1;
      check_all_zero();
      i_rst = 1'b0;

      // Leading blank: reaches vblank from SEARCH, no eof.
      for (int i = 0; i < 30; i++) begin
         tick(1'b0, 16'h0);
         check("eof_search", o_eof, 1'b0);
      end

      send_frame(V, -1, 0, 1'b1);   // clean, lock
      send_frame(V, -1, 0, 1'b1);   // clean, stays locked
      send_frame(V, 1, H - 1, 1'b1); // short line
      send_frame(V, -1, 0, 1'b1);   // relock
      send_frame(V, 2, H + 1, 1'b1); // long line, extra pixel suppressed
      send_frame(V, -1, 0, 1'b1);
      send_frame(V - 1, -1, 0, 1'b1); // too few lines
      send_frame(V + 1, -1, 0, 1'b1); // too many lines, last row suppressed
      send_frame(V, 0, 1, 1'b1);    // one-pixel line
      send_frame(V, 3, 40, 1'b1);   // line length saturates the counter
      send_frame(V, -1, 0, 1'b1);

      // Reset in the middle of line 2.
      send_line(H, 0, 1'b1);
      send_line(H, 1, 1'b1);
      for (int i = 0; i < 4; i++) tick(1'b1, 16'h1234);
      do_reset();
      for (int i = 0; i < 2; i++) begin
         tick(1'b1, 16'h5555);
         check("rst_hold", {o_valid, o_eol, o_locked}, 64'h0);
      end
      i_rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick(1'b1, 16'h7777);
         check("abort_valid", o_valid, 1'b0);
         check("abort_sof", o_sof, 1'b0);
      end
      for (int i = 0; i < HB + VB; i++) begin
         tick(1'b0, 16'h0);
         check("abort_evt", {o_eol, o_eof, o_err_hlen, o_err_vlen}, 64'h0);
      end
      send_frame(V, -1, 0, 1'b1);

      // Mid-frame start with no leading blank.
      do_reset();
      @(posedge i_clk);
      #1;
      i_rst = 1'b0;
      send_frame(V - 1, -1, 0, 1'b0);
      send_frame(V, -1, 0, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
